// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - instruction handshake between fetch and the ALU op sequencer
interface alu_op_sequencer_if;
    logic       instrValid;
    logic       instrReady;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;

    modport master (
        output instrValid,
        output opcode,
        output funct3,
        output funct7b5,
        input  instrReady
    );

    modport slave (
        input  instrValid,
        input  opcode,
        input  funct3,
        input  funct7b5,
        output instrReady
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle ALU control sequencer with memory, write-back and PC strobes
module alu_op_sequencer #(
    parameter int ALU_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    alu_op_sequencer_if.slave    instr,
    input  logic                 zero,
    output logic [3:0]           ALUControl,
    output logic                 ALUSrc,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemToReg,
    output logic                 RegWrite,
    output logic                 PCSrc,
    output logic                 PCWrite,
    output logic                 illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Counter reload: EXEC lasts ALU_LATENCY cycles, exiting when the count reaches zero.
    localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM,
        WB,
        BRANCH,
        TRAP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic       f7_q;
    logic [3:0] cnt;
    logic       ready;

    logic       dec_valid;
    logic [3:0] dec_ctrl;
    logic       dec_src;
    logic       is_load;
    logic       is_store;
    logic       is_branch;

    assign instr.instrReady = ready;

    assign is_load   = (op_q == OP_LOAD);
    assign is_store  = (op_q == OP_STORE);
    assign is_branch = (op_q == OP_BRANCH);

    // Classify the captured instruction fields into an ALU operation and operand select.
    always_comb begin
        dec_valid = 1'b0;
        dec_ctrl  = ALU_ADD;
        dec_src   = 1'b0;
        case (op_q)
            OP_R: begin
                dec_src = 1'b0;
                case (f3_q)
                    3'b000: begin dec_valid = 1'b1; dec_ctrl = f7_q ? ALU_SUB : ALU_ADD; end
                    3'b111: begin dec_valid = 1'b1; dec_ctrl = ALU_AND; end
                    3'b110: begin dec_valid = 1'b1; dec_ctrl = ALU_OR;  end
                    default: dec_valid = 1'b0;
                endcase
            end
            OP_I: begin
                dec_src = 1'b1;
                case (f3_q)
                    3'b000: begin dec_valid = 1'b1; dec_ctrl = ALU_ADD; end
                    3'b111: begin dec_valid = 1'b1; dec_ctrl = ALU_AND; end
                    3'b110: begin dec_valid = 1'b1; dec_ctrl = ALU_OR;  end
                    default: dec_valid = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                dec_valid = (f3_q == 3'b010);
                dec_ctrl  = ALU_ADD;
                dec_src   = 1'b1;
            end
            OP_BRANCH: begin
                dec_valid = (f3_q == 3'b000);
                dec_ctrl  = ALU_SUB;
                dec_src   = 1'b0;
            end
            default: dec_valid = 1'b0;
        endcase
    end

    // State register; asynchronous reset abandons any instruction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore-decoded strobes.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemToReg  = 1'b0;
        RegWrite  = 1'b0;
        PCSrc     = 1'b0;
        PCWrite   = 1'b0;
        illegal   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (instr.instrValid) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                state_nxt = dec_valid ? EXEC : TRAP;
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    if (is_load || is_store) begin
                        state_nxt = MEM;
                    end else if (is_branch) begin
                        state_nxt = BRANCH;
                    end else begin
                        state_nxt = WB;
                    end
                end
            end
            MEM: begin
                MemRead   = is_load;
                MemWrite  = is_store;
                PCWrite   = is_store;
                state_nxt = is_load ? WB : IDLE;
            end
            WB: begin
                RegWrite  = 1'b1;
                PCWrite   = 1'b1;
                MemToReg  = is_load;
                state_nxt = IDLE;
            end
            BRANCH: begin
                PCWrite   = 1'b1;
                PCSrc     = zero;
                state_nxt = IDLE;
            end
            TRAP: begin
                illegal   = 1'b1;
                PCWrite   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture registers, ALU control registers and the latency counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q       <= 7'd0;
            f3_q       <= 3'd0;
            f7_q       <= 1'b0;
            cnt        <= 4'd0;
            ALUControl <= ALU_AND;
            ALUSrc     <= 1'b0;
        end else begin
            if (state == IDLE && instr.instrValid) begin
                op_q <= instr.opcode;
                f3_q <= instr.funct3;
                f7_q <= instr.funct7b5;
            end
            if (state == DECODE && dec_valid) begin
                ALUControl <= dec_ctrl;
                ALUSrc     <= dec_src;
                cnt        <= LAT_LOAD;
            end
            if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle control sequencer that issues operations to the datapath ALU and consumes its result flags. It accepts one decoded instruction at a time from the fetch stage, drives the 4-bit ALU control code and operand select, and waits out the ALU's registered latency. It then samples `zero` for branches and sequences the memory, write-back and PC-update strobes. It sits between the instruction register and the ALU/register-file/data-memory datapath.

## Interface
- `ALU_LATENCY`, default 1: clock edges between ALU control being applied and ALU result/`zero` being valid; range 1–15.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `instrValid` in 1: fetch presents a valid instruction.
- `instrReady` out 1: sequencer can accept an instruction.
- `opcode` in 7: instruction bits [6:0].
- `funct3` in 3: instruction bits [14:12].
- `funct7b5` in 1: instruction bit 30.
- `zero` in 1: ALU zero flag (registered in the ALU).
- `ALUControl` out 4: operation code to the ALU: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- `ALUSrc` out 1: 0 selects register operand 2, 1 selects the immediate.
- `MemRead` out 1: data-memory read strobe.
- `MemWrite` out 1: data-memory write strobe.
- `MemToReg` out 1: write-back selects memory data.
- `RegWrite` out 1: register-file write strobe.
- `PCSrc` out 1: PC selects the branch target.
- `PCWrite` out 1: PC update strobe; marks instruction completion.
- `illegal` out 1: one-cycle pulse on an unsupported encoding.

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB, BRANCH, TRAP. Strobe outputs are Moore-decoded from state.
- IDLE:
  - `instrReady`=1.
  - On `instrValid`, capture `opcode`/`funct3`/`funct7b5` into internal registers, then go to DECODE.
  - Inputs are ignored in every other state.
- DECODE: classify the captured fields and load the `ALUControl`/`ALUSrc` registers.
  - 0110011 R-type:
    - funct3 000 with funct7b5 0 → ADD; with funct7b5 1 → SUB.
    - 111 → AND; 110 → OR.
    - `ALUSrc`=0.
  - 0010011 I-type: 000 → ADD, 111 → AND, 110 → OR; `ALUSrc`=1.
  - 0000011 load: requires funct3 010; ADD, `ALUSrc`=1.
  - 0100011 store: requires funct3 010; ADD, `ALUSrc`=1.
  - 1100011 beq: requires funct3 000; SUB, `ALUSrc`=0.
  - Any other encoding → TRAP, with `ALUControl`/`ALUSrc` left unchanged.
  - Valid encodings → EXEC, with the latency counter loaded to `ALU_LATENCY`-1.
- EXEC: hold for `ALU_LATENCY` cycles, counting down. At count 0, exit as follows:
  - R/I-type → WB.
  - Load or store → MEM.
  - beq → BRANCH.
- MEM:
  - Load: `MemRead`=1 → WB.
  - Store: `MemWrite`=1, `PCWrite`=1 → IDLE.
- WB: `RegWrite`=1, `PCWrite`=1 → IDLE. `MemToReg`=1 for loads, otherwise 0.
- BRANCH: `PCWrite`=1, `PCSrc`=`zero` (sampled this cycle) → IDLE.
- TRAP: `illegal`=1, `PCWrite`=1 (skip the instruction) → IDLE.
- `ALUControl`/`ALUSrc` are registers. They update only on DECODE exit with a valid encoding and hold through EXEC to completion and in IDLE, so the registered ALU re-evaluates the same operation every cycle.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE; capture registers, counter, `ALUControl`=0000 and `ALUSrc`=0 are cleared.
  - `instrReady`=1 while in IDLE; all strobes and `illegal` are 0.
  - An instruction in flight is abandoned, with no strobe issued after reset asserts.
- Accept edge A, where `instrValid`&`instrReady` is sampled high. With L=`ALU_LATENCY`, cycles are counted after A:
  - Cycle 1 is DECODE; cycles 2..L+1 are EXEC.
  - R/I-type: WB in cycle L+2.
  - Load: MEM in L+2, WB in L+3.
  - Store: MEM in L+2.
  - beq: BRANCH in L+2.
  - Illegal encoding: TRAP in cycle 2.
  - IDLE resumes the cycle after the completing state; back-to-back issue is possible then.
- `zero` is sampled only in BRANCH. Its value during EXEC is don't-care.
- Every strobe is high for exactly one cycle per instruction.
- `instrValid` held high in IDLE after completion is treated as a new instruction.

## Test plan
- Reset low mid-EXEC of an R-type add, L=1 → same cycle: IDLE, all strobes 0, `ALUControl`=0000, `instrReady`=1; no `RegWrite` follows.
- R-type sub (0110011/000/1), L=1 → `ALUControl`=0110 and `ALUSrc`=0 from cycle 2; `RegWrite`=`PCWrite`=1 in cycle 3 only; `instrReady`=1 in cycle 4.
- lw (0000011/010), L=3 → EXEC cycles 2–4 with `ALUControl`=0010, `ALUSrc`=1; `MemRead` in cycle 5; `RegWrite`+`MemToReg` in cycle 6.
- beq with `zero`=1, then beq with `zero`=0 → BRANCH cycle with `PCWrite`=1 and `PCSrc`=1, then `PCSrc`=0; `RegWrite` never asserts.
- Opcode 1111111, and R-type funct3 001 → `illegal`=`PCWrite`=1 in cycle 2; `ALUControl` keeps its previous value; no other strobes.
- `instrValid` held high for back-to-back sw then andi (0010011/111) → exactly two accepts; `MemWrite` once, then `ALUControl`=0000, `ALUSrc`=1, `RegWrite` once.
